parking_timer_scheduler: RTL and testbench

Shared occupancy-time controller for the parking lot: one internal prescaler produces a time-unit tick, and one sequencer keeps a per-slot elapsed-time counter for every parking slot. Entry/exit requests from the slot sensors are arbitrated round-robin and serviced one at a time. On exit the slot's elapsed time is reported for billing and display. It replaces per-slot divided clocks with single-clock tick enables.

---
 rtl/parking_pkg.sv | 16 +
 rtl/parking_timer_scheduler_tick_prescaler.sv | 29 ++
 rtl/parking_timer_scheduler.sv | 140 ++++++++++++++
 tb/tb_parking_timer_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking occupancy-time scheduler.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    SWEEP = 2'd2
  } state_t;

  localparam int DEFAULT_DIV = 10_000_000;

  function automatic int slot_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parking_timer_scheduler_tick_prescaler.sv
// Free-running divider: TICK is high for one cycle every DIV cycles.
module tick_prescaler
  import parking_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/parking_timer_scheduler.sv
// Per-slot elapsed-time tracking with one shared incrementer and a round-robin
// entry/exit sequencer. Define PARKING_TIMER_SAT_EN to saturate timers instead of wrapping.
module parking_timer_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DIV       = DEFAULT_DIV,
  parameter int TIME_W    = 16
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_SLOTS-1:0]             ENTER_REQ,
  input  logic [NUM_SLOTS-1:0]             EXIT_REQ,
  output logic [NUM_SLOTS-1:0]             REQ_ACK,
  output logic [NUM_SLOTS-1:0]             OCCUPIED,
  output logic                             DONE_VALID,
  output logic [slot_idx_w(NUM_SLOTS)-1:0] DONE_SLOT,
  output logic [TIME_W-1:0]                DONE_TIME,
  output logic                             TICK
);

  localparam int IW = slot_idx_w(NUM_SLOTS);
  localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_SLOTS - 1);

  state_t               state;
  logic                 tick_pending;
  logic                 sweep_start;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        grant;
  logic                 grant_exit;
  logic [IW-1:0]        sweep_idx;
  logic [NUM_SLOTS-1:0] mask;
  logic [NUM_SLOTS-1:0] occ;
  logic [NUM_SLOTS-1:0] req;
  logic [NUM_SLOTS-1:0] grant_onehot;
  logic [IW-1:0]        sel;
  logic                 found;
  logic [TIME_W-1:0]    slot_time [NUM_SLOTS];

  function automatic logic [TIME_W-1:0] bump(input logic [TIME_W-1:0] t);
`ifdef PARKING_TIMER_SAT_EN
    return (&t) ? t : t + TIME_W'(1);
`else
    return t + TIME_W'(1);
`endif
  endfunction

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (TICK)
  );

  // A tick seen in IDLE goes straight to SWEEP; otherwise it is remembered.
  assign sweep_start  = (state == IDLE) && (tick_pending || TICK);
  assign req          = (ENTER_REQ | EXIT_REQ) & ~mask;
  assign grant_onehot = NUM_SLOTS'(1) << grant;

  always_comb begin : arbiter
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idx = (int'(ptr) + k) % NUM_SLOTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      tick_pending <= 1'b0;
      ptr          <= '0;
      grant        <= '0;
      grant_exit   <= 1'b0;
      sweep_idx    <= '0;
      mask         <= '0;
      occ          <= '0;
      DONE_SLOT    <= '0;
      DONE_TIME    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_time[i] <= '0;
    end else begin
      mask <= '0;
      if (sweep_start) begin
        tick_pending <= 1'b0;
      end else if (TICK) begin
        tick_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sweep_start) begin
            state     <= SWEEP;
            sweep_idx <= '0;
          end else if (found) begin
            state      <= SERVE;
            grant      <= sel;
            grant_exit <= EXIT_REQ[sel];
            ptr        <= (sel == LAST_SLOT) ? '0 : sel + IW'(1);
            if (EXIT_REQ[sel] && occ[sel]) begin
              DONE_SLOT <= sel;
              DONE_TIME <= slot_time[sel];
            end
          end
        end
        // The served slot is hidden from the arbiter for one cycle while its requester drops the level.
        SERVE: begin
          state <= IDLE;
          mask  <= grant_onehot;
          if (grant_exit) begin
            if (occ[grant]) begin
              occ[grant]       <= 1'b0;
              slot_time[grant] <= '0;
            end
          end else if (!occ[grant]) begin
            occ[grant]       <= 1'b1;
            slot_time[grant] <= '0;
          end
        end
        SWEEP: begin
          if (occ[sweep_idx]) slot_time[sweep_idx] <= bump(slot_time[sweep_idx]);
          if (sweep_idx == LAST_SLOT) begin
            state <= IDLE;
          end else begin
            sweep_idx <= sweep_idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign OCCUPIED   = occ;
  assign REQ_ACK    = (state == SERVE) ? grant_onehot : '0;
  assign DONE_VALID = (state == SERVE) && grant_exit && occ[grant];

endmodule

// File: tb/tb_parking_timer_scheduler.sv
// Bench for parking_timer_scheduler: vector table, corner sequences and a randomized run.
module tb_parking_timer_scheduler;

  localparam int N     = 4;
  localparam int D     = 8;
  localparam int TW    = 3;
  localparam int LIMIT = 40;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  ENTER_REQ = '0;
  logic [N-1:0]  EXIT_REQ  = '0;
  logic [N-1:0]  REQ_ACK;
  logic [N-1:0]  OCCUPIED;
  logic          DONE_VALID;
  logic [1:0]    DONE_SLOT;
  logic [TW-1:0] DONE_TIME;
  logic          TICK;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  parking_timer_scheduler #(.NUM_SLOTS(N), .DIV(D), .TIME_W(TW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ENTER_REQ  (ENTER_REQ),
    .EXIT_REQ   (EXIT_REQ),
    .REQ_ACK    (REQ_ACK),
    .OCCUPIED   (OCCUPIED),
    .DONE_VALID (DONE_VALID),
    .DONE_SLOT  (DONE_SLOT),
    .DONE_TIME  (DONE_TIME),
    .TICK       (TICK)
  );

  typedef struct {
    logic [N-1:0] enter;
    logic [N-1:0] exit_r;
    int           ticks;
    logic [N-1:0] ack;
    int           dv;
    int           slot;
    int           tm;
    logic [N-1:0] occ;
  } vec_t;

  vec_t vecs [8];

  // randomized-phase model state
  int           m_occ  [N];
  int           m_cnt  [N];
  int           wait_c [N];
  logic [N-1:0] en_r;
  logic [N-1:0] ex_r;
  int           cyc;
  int           acked;
  int           tick_exp;
  int           occ_exp;
  int           r;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int fold(input int c);
`ifdef PARKING_TIMER_SAT_EN
    return (c > (1 << TW) - 1) ? (1 << TW) - 1 : c;
`else
    return c % (1 << TW);
`endif
  endfunction

  task automatic do_reset();
    RST       = 1'b1;
    ENTER_REQ = '0;
    EXIT_REQ  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      @(negedge CLK);
      while (!TICK && g < 4 * D) begin
        @(negedge CLK);
        g++;
      end
      chk("tick_seen", int'(TICK), 1);
    end
  endtask

  task automatic do_req(input logic [N-1:0] en, input logic [N-1:0] ex,
                        output logic [N-1:0] ack, output int dv, output int slot,
                        output int tm, output logic [N-1:0] occ);
    ENTER_REQ = en;
    EXIT_REQ  = ex;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (REQ_ACK != '0) break;
    end
    ack       = REQ_ACK;
    dv        = int'(DONE_VALID);
    slot      = int'(DONE_SLOT);
    tm        = int'(DONE_TIME);
    ENTER_REQ = '0;
    EXIT_REQ  = '0;
    @(negedge CLK);
    occ = OCCUPIED;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [N-1:0] ack;
    logic [N-1:0] occ;
    int           dv;
    int           slot;
    int           tm;
    int           k;
    int           g;
    int           prev_ack;
    int           gap_ok;
    int           order [$];

    vecs[0] = '{4'b0100, 4'b0000, 1,  4'b0100, 0, 0, 0, 4'b0100};
    vecs[1] = '{4'b0000, 4'b0100, 5,  4'b0100, 1, 2, 5, 4'b0000};
    vecs[2] = '{4'b0000, 4'b0001, 1,  4'b0001, 0, 2, 5, 4'b0000};
    vecs[3] = '{4'b0010, 4'b0000, 1,  4'b0010, 0, 2, 5, 4'b0010};
    vecs[4] = '{4'b0010, 4'b0000, 1,  4'b0010, 0, 2, 5, 4'b0010};
    vecs[5] = '{4'b0000, 4'b0010, 2,  4'b0010, 1, 1, 3, 4'b0000};
    vecs[6] = '{4'b1000, 4'b0000, 1,  4'b1000, 0, 1, 3, 4'b1000};
    vecs[7] = '{4'b0000, 4'b1000, 10, 4'b1000, 1, 3, fold(10), 4'b0000};

    // reset values and prescaler phase
    do_reset();
    chk("rst_ack", int'(REQ_ACK), 0);
    chk("rst_occ", int'(OCCUPIED), 0);
    chk("rst_dv", int'(DONE_VALID), 0);
    chk("rst_slot", int'(DONE_SLOT), 0);
    chk("rst_time", int'(DONE_TIME), 0);
    for (int c = 0; c < 25; c++) begin
      chk($sformatf("tick_c%0d", c), int'(TICK), (c % D == D - 1) ? 1 : 0);
      chk($sformatf("idle_out_c%0d", c), int'(REQ_ACK) | int'(OCCUPIED) | int'(DONE_VALID), 0);
      @(negedge CLK);
    end

    // vector table
    for (int i = 0; i < 8; i++) begin
      wait_ticks(vecs[i].ticks);
      do_req(vecs[i].enter, vecs[i].exit_r, ack, dv, slot, tm, occ);
      chk($sformatf("vec%0d_ack", i), int'(ack), int'(vecs[i].ack));
      chk($sformatf("vec%0d_dv", i), dv, vecs[i].dv);
      chk($sformatf("vec%0d_slot", i), slot, vecs[i].slot);
      chk($sformatf("vec%0d_time", i), tm, vecs[i].tm);
      chk($sformatf("vec%0d_occ", i), int'(occ), int'(vecs[i].occ));
    end

    // all four slots request together
    wait_ticks(1);
    ENTER_REQ = 4'b1111;
    g = 0;
    prev_ack = 0;
    gap_ok = 1;
    while (order.size() < 4 && g < 200) begin
      @(negedge CLK);
      g++;
      if (REQ_ACK != '0) begin
        if (prev_ack != 0) gap_ok = 0;
        for (int s = 0; s < N; s++) begin
          if (REQ_ACK[s]) begin
            order.push_back(s);
            ENTER_REQ[s] = 1'b0;
          end
        end
        prev_ack = 1;
      end else begin
        prev_ack = 0;
      end
    end
    ENTER_REQ = '0;
    chk("rr_count", order.size(), 4);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("rr_order%0d", s), (s < order.size()) ? order[s] : -1, s);
    end
    chk("rr_gap", gap_ok, 1);
    @(negedge CLK);
    chk("rr_occ", int'(OCCUPIED), 15);

    // request arriving with a tick waits for the sweep and misses that tick
    do_reset();
    wait_ticks(1);
    repeat (D) @(negedge CLK);
    chk("tk_tick", int'(TICK), 1);
    ENTER_REQ = 4'b0010;
    for (k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (REQ_ACK != '0) break;
    end
    chk("tk_latency", k, 6);
    chk("tk_ack", int'(REQ_ACK), 2);
    ENTER_REQ = '0;
    EXIT_REQ  = 4'b0010;
    for (k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (REQ_ACK != '0) break;
    end
    chk("tk_exit_ack", int'(REQ_ACK), 2);
    chk("tk_exit_dv", int'(DONE_VALID), 1);
    chk("tk_exit_slot", int'(DONE_SLOT), 1);
    chk("tk_exit_time", int'(DONE_TIME), 1);
    EXIT_REQ = '0;

    // reset in the middle of a sweep
    wait_ticks(1);
    do_req(4'b0001, 4'b0000, ack, dv, slot, tm, occ);
    wait_ticks(1);
    do_req(4'b0010, 4'b0000, ack, dv, slot, tm, occ);
    chk("ms_occ_before", int'(occ), 3);
    wait_ticks(1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("ms_occ", int'(OCCUPIED), 0);
    chk("ms_ack", int'(REQ_ACK), 0);
    chk("ms_dv", int'(DONE_VALID), 0);
    RST      = 1'b0;
    EXIT_REQ = 4'b0001;
    for (k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (REQ_ACK != '0) break;
    end
    chk("ms_exit_latency", k, 1);
    chk("ms_exit_ack", int'(REQ_ACK), 1);
    chk("ms_exit_dv", int'(DONE_VALID), 0);
    chk("ms_exit_slot", int'(DONE_SLOT), 0);
    chk("ms_exit_time", int'(DONE_TIME), 0);
    EXIT_REQ = '0;

    // randomized traffic against an event-level model
    do_reset();
    for (int s = 0; s < N; s++) begin
      m_occ[s]  = 0;
      m_cnt[s]  = 0;
      wait_c[s] = 0;
    end
    en_r = '0;
    ex_r = '0;
    cyc  = 0;
    for (int step = 0; step < 3000; step++) begin
      tick_exp = ((cyc % D) == D - 1) ? 1 : 0;
      chk("rnd_tick", int'(TICK), tick_exp);
      occ_exp = 0;
      for (int s = 0; s < N; s++) occ_exp = occ_exp | (m_occ[s] << s);
      chk("rnd_occ", int'(OCCUPIED), occ_exp);
      acked = -1;
      if (REQ_ACK != '0) begin
        chk("rnd_onehot", $countones(REQ_ACK), 1);
        for (int s = 0; s < N; s++) if (REQ_ACK[s]) acked = s;
        chk("rnd_ack_requested", int'(en_r[acked] | ex_r[acked]), 1);
        chk("rnd_wait", (wait_c[acked] <= LIMIT) ? 1 : 0, 1);
        if (ex_r[acked]) begin
          chk("rnd_dv_exit", int'(DONE_VALID), m_occ[acked]);
          if (m_occ[acked] != 0) begin
            chk("rnd_slot", int'(DONE_SLOT), acked);
            chk("rnd_time", int'(DONE_TIME), fold(m_cnt[acked]));
          end
          m_occ[acked] = 0;
          m_cnt[acked] = 0;
          ex_r[acked]  = 1'b0;
        end else begin
          chk("rnd_dv_enter", int'(DONE_VALID), 0);
          if (m_occ[acked] == 0) begin
            m_occ[acked] = 1;
            m_cnt[acked] = 0;
          end
          en_r[acked] = 1'b0;
        end
        wait_c[acked] = 0;
      end else begin
        chk("rnd_dv_idle", int'(DONE_VALID), 0);
      end
      if (tick_exp != 0) begin
        for (int s = 0; s < N; s++) if (m_occ[s] != 0) m_cnt[s]++;
      end
      for (int s = 0; s < N; s++) begin
        if (en_r[s] | ex_r[s]) begin
          wait_c[s]++;
        end else if (s != acked && $urandom_range(0, 7) == 0) begin
          r = $urandom_range(0, 9);
          if (r < 5) en_r[s] = 1'b1;
          else if (r < 9) ex_r[s] = 1'b1;
          else begin
            en_r[s] = 1'b1;
            ex_r[s] = 1'b1;
          end
          wait_c[s] = 0;
        end
      end
      ENTER_REQ = en_r;
      EXIT_REQ  = ex_r;
      @(negedge CLK);
      cyc++;
    end
    for (int s = 0; s < N; s++) begin
      chk($sformatf("rnd_pending%0d", s), (wait_c[s] <= LIMIT) ? 1 : 0, 1);
    end
    ENTER_REQ = '0;
    EXIT_REQ  = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
